// File: rtl/fetch_pkg.sv
// Shared widths, opcodes and state encoding for the fetch stage and its FD register.
package fetch_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;

   localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 16'h0000;
   localparam logic [PC_W-1:0]    PC_STEP          = 16'd2;
   localparam logic [3:0]         HLT_OPC          = 4'hF;
   localparam logic [INSTR_W-1:0] NOP_INSTR        = 16'h0000;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

   function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: 4] == HLT_OPC;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
   import fetch_pkg::*;

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder/subtractor built from four 4-bit groups.
module cla_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sub,
   output logic [15:0] sum
);

   logic [15:0] b_eff;
   logic [15:0] g;
   logic [15:0] p;
   logic [2:0]  grp_g;
   logic [2:0]  grp_p;
   logic [3:0]  grp_c;

   assign b_eff = b ^ {16{sub}};
   assign g     = a & b_eff;
   assign p     = a ^ b_eff;

   // Group carries come straight from group generate/propagate, not from each other.
   assign grp_c[0] = sub;
   assign grp_c[1] = grp_g[0] | (grp_p[0] & sub);
   assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & sub);
   assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[2] & grp_p[1] & grp_p[0] & sub);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_grp
         logic [3:0] gl;
         logic [3:0] pl;
         logic [3:0] cl;

         assign gl = g[gi*4 +: 4];
         assign pl = p[gi*4 +: 4];

         assign cl[0] = grp_c[gi];
         assign cl[1] = gl[0] | (pl[0] & grp_c[gi]);
         assign cl[2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & grp_c[gi]);
         assign cl[3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                      | (pl[2] & pl[1] & pl[0] & grp_c[gi]);

         assign sum[gi*4 +: 4] = pl ^ cl;

         if (gi < 3) begin : g_lookahead
            assign grp_p[gi] = &pl;
            assign grp_g[gi] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                             | (pl[3] & pl[2] & pl[1] & gl[0]);
         end
      end
   endgenerate

endmodule

// File: rtl/fetch_decode_reg.sv
// Fetch/Decode pipeline register with valid bit; squash beats load, otherwise holds.
module fetch_decode_reg
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               squash,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [PC_W-1:0]    next_pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [PC_W-1:0]    curr_pc,
   output logic [PC_W-1:0]    next_pc,
   output logic [INSTR_W-1:0] instr,
   output logic               valid
);

   logic [PC_W-1:0]    curr_pc_q, curr_pc_d;
   logic [PC_W-1:0]    next_pc_q, next_pc_d;
   logic [INSTR_W-1:0] instr_q,   instr_d;
   logic               valid_q,   valid_d;

   always_comb begin
      curr_pc_d = curr_pc_q;
      next_pc_d = next_pc_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      if (squash) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (load) begin
         curr_pc_d = pc_in;
         next_pc_d = next_pc_in;
         instr_d   = instr_in;
         valid_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curr_pc_q <= '0;
         next_pc_q <= '0;
         instr_q   <= NOP_INSTR;
         valid_q   <= 1'b0;
      end else begin
         curr_pc_q <= curr_pc_d;
         next_pc_q <= next_pc_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
      end
   end

   assign curr_pc = curr_pc_q;
   assign next_pc = next_pc_q;
   assign instr   = instr_q;
   assign valid   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, fetches over req/ack, feeds the FD register,
// honours decode stall/flush and stops on HLT.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic [PC_W-1:0]    branch_target,
   fetch_stage_if.master      imem,
   output logic [PC_W-1:0]    curr_pc_fd,
   output logic [PC_W-1:0]    next_pc_fd,
   output logic [INSTR_W-1:0] curr_instr_fd,
   output logic               valid_fd,
   output logic               halted
);

   fetch_state_e       state_q,   state_d;
   logic [PC_W-1:0]    pc_q,      pc_d;
   logic [PC_W-1:0]    addr_q,    addr_d;
   logic               req_q,     req_d;
   logic               discard_q, discard_d;
   logic [INSTR_W-1:0] skid_q,    skid_d;
   logic               halted_q,  halted_d;

   logic               ack;
   logic               fd_load;
   logic               fd_squash;
   logic [INSTR_W-1:0] fd_instr;
   logic [PC_W-1:0]    pc_plus2;

   assign ack = imem.imem_ack & req_q;

   cla_16bit u_pc_add (
      .a   (pc_q),
      .b   (PC_STEP),
      .sub (1'b0),
      .sum (pc_plus2)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      req_d     = req_q;
      discard_d = discard_q;
      skid_d    = skid_q;
      halted_d  = halted_q;
      fd_load   = 1'b0;
      fd_squash = 1'b0;
      fd_instr  = imem.imem_rdata;

      if (flush) begin
         fd_squash = 1'b1;
         pc_d      = branch_target;
         skid_d    = NOP_INSTR;
         halted_d  = 1'b0;
         state_d   = FETCH;
         // A pending request cannot be withdrawn; its data is dropped when it lands.
         if (req_q && !ack) begin
            discard_d = 1'b1;
         end else begin
            discard_d = 1'b0;
            req_d     = 1'b1;
            addr_d    = branch_target;
         end
      end else if (discard_q) begin
         if (ack) begin
            discard_d = 1'b0;
            req_d     = 1'b1;
            addr_d    = pc_q;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (ack) begin
                  if (stall) begin
                     skid_d  = imem.imem_rdata;
                     state_d = HOLD;
                     req_d   = 1'b0;
                  end else begin
                     fd_load = 1'b1;
                  end
               end else if (!req_q) begin
                  req_d  = 1'b1;
                  addr_d = pc_q;
               end
            end
            HOLD: begin
               if (!stall) begin
                  fd_load  = 1'b1;
                  fd_instr = skid_q;
               end
            end
            HALT:    ;
            default: state_d = FETCH;
         endcase

         // Committing an instruction to FD advances the PC and decides whether to keep fetching.
         if (fd_load) begin
            pc_d = pc_plus2;
            if (is_hlt(fd_instr)) begin
               halted_d = 1'b1;
               state_d  = HALT;
               req_d    = 1'b0;
            end else begin
               state_d = FETCH;
               req_d   = 1'b1;
               addr_d  = pc_plus2;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         req_q     <= 1'b0;
         discard_q <= 1'b0;
         skid_q    <= NOP_INSTR;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         req_q     <= req_d;
         discard_q <= discard_d;
         skid_q    <= skid_d;
         halted_q  <= halted_d;
      end
   end

   fetch_decode_reg u_fd (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (fd_load),
      .squash     (fd_squash),
      .pc_in      (pc_q),
      .next_pc_in (pc_plus2),
      .instr_in   (fd_instr),
      .curr_pc    (curr_pc_fd),
      .next_pc    (next_pc_fd),
      .instr      (curr_instr_fd),
      .valid      (valid_fd)
   );

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign halted         = halted_q;

   // Memory must only acknowledge an outstanding request.
   ack_without_req_a: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem.imem_ack && !req_q));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a latency-configurable instruction memory.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic [15:0] branch_target;
   logic [15:0] curr_pc_fd;
   logic [15:0] next_pc_fd;
   logic [15:0] curr_instr_fd;
   logic        valid_fd;
   logic        halted;

   int n_cmp = 0;
   int n_err = 0;
   int lat_cyc;
   int wait_cnt;

   fetch_stage_if bus ();

   fetch_stage u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .branch_target (branch_target),
      .imem          (bus),
      .curr_pc_fd    (curr_pc_fd),
      .next_pc_fd    (next_pc_fd),
      .curr_instr_fd (curr_instr_fd),
      .valid_fd      (valid_fd),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: ack on the lat_cyc-th cycle of a request; word = addr ^ 0x1000, HLT at 0x0020.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)             wait_cnt <= 0;
      else if (bus.imem_ack)  wait_cnt <= 0;
      else if (bus.imem_req)  wait_cnt <= wait_cnt + 1;
   end

   assign bus.imem_ack   = bus.imem_req && (wait_cnt == lat_cyc - 1);
   assign bus.imem_rdata = (bus.imem_addr == 16'h0020) ? 16'hF000 : (bus.imem_addr ^ 16'h1000);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = 16'h0000; lat_cyc = 1;
      tick(); tick();
      chk("rst_req",    32'(bus.imem_req), 32'd0);
      chk("rst_valid",  32'(valid_fd),     32'd0);
      chk("rst_instr",  32'(curr_instr_fd), 32'h0000);
      chk("rst_pc",     32'(curr_pc_fd),   32'h0000);
      chk("rst_npc",    32'(next_pc_fd),   32'h0000);
      chk("rst_halted", 32'(halted),       32'd0);

      rst_n = 1'b1;
      tick();
      chk("first_req",   32'(bus.imem_req),  32'd1);
      chk("first_addr",  32'(bus.imem_addr), 32'h0000);
      chk("first_valid", 32'(valid_fd),      32'd0);

      // Zero-wait memory: one FD load per cycle.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("zw_pc",    32'(curr_pc_fd),    32'(i * 2));
         chk("zw_npc",   32'(next_pc_fd),    32'(i * 2 + 2));
         chk("zw_instr", 32'(curr_instr_fd), 32'(16'h1000 | 16'(i * 2)));
         chk("zw_valid", 32'(valid_fd),      32'd1);
      end

      // Three-cycle latency on the request for 0x0006.
      lat_cyc = 3;
      tick();
      chk("lat_req1",  32'(bus.imem_req),  32'd1);
      chk("lat_addr1", 32'(bus.imem_addr), 32'h0006);
      chk("lat_pc1",   32'(curr_pc_fd),    32'h0004);
      tick();
      chk("lat_addr2", 32'(bus.imem_addr), 32'h0006);
      chk("lat_ack2",  32'(bus.imem_ack),  32'd1);
      chk("lat_pc2",   32'(curr_pc_fd),    32'h0004);
      tick();
      chk("lat_pc3",    32'(curr_pc_fd),    32'h0006);
      chk("lat_instr3", 32'(curr_instr_fd), 32'h1006);
      chk("lat_addr3",  32'(bus.imem_addr), 32'h0008);

      // Stall coincident with the ack for 0x0010.
      lat_cyc = 1;
      repeat (4) tick();
      chk("st_pre_pc",   32'(curr_pc_fd),    32'h000E);
      chk("st_pre_addr", 32'(bus.imem_addr), 32'h0010);
      stall = 1'b1;
      tick();
      chk("st_hold_pc1", 32'(curr_pc_fd),   32'h000E);
      chk("st_hold_req", 32'(bus.imem_req), 32'd0);
      tick();
      chk("st_hold_pc2", 32'(curr_pc_fd),   32'h000E);
      stall = 1'b0;
      tick();
      chk("st_rel_pc",    32'(curr_pc_fd),    32'h0010);
      chk("st_rel_instr", 32'(curr_instr_fd), 32'h1010);
      chk("st_rel_addr",  32'(bus.imem_addr), 32'h0012);
      chk("st_rel_req",   32'(bus.imem_req),  32'd1);

      // Flush while the request for 0x0012 is still waiting.
      lat_cyc = 3;
      flush = 1'b1; branch_target = 16'h0040;
      tick();
      flush = 1'b0;
      chk("fl_valid", 32'(valid_fd),      32'd0);
      chk("fl_instr", 32'(curr_instr_fd), 32'h0000);
      chk("fl_addr",  32'(bus.imem_addr), 32'h0012);
      tick();
      chk("fl_old_ack", 32'(bus.imem_ack), 32'd1);
      tick();
      chk("fl_new_addr", 32'(bus.imem_addr), 32'h0040);
      chk("fl_drop",     32'(valid_fd),      32'd0);
      repeat (3) tick();
      chk("fl_tgt_pc",    32'(curr_pc_fd),    32'h0040);
      chk("fl_tgt_instr", 32'(curr_instr_fd), 32'h1040);

      // Flush coincident with an ack, landing on the HLT at 0x0020.
      lat_cyc = 1;
      flush = 1'b1; branch_target = 16'h0020;
      tick();
      flush = 1'b0;
      chk("hlt_fl_valid", 32'(valid_fd),      32'd0);
      chk("hlt_fl_addr",  32'(bus.imem_addr), 32'h0020);
      tick();
      chk("hlt_pc",     32'(curr_pc_fd),    32'h0020);
      chk("hlt_instr",  32'(curr_instr_fd), 32'hF000);
      chk("hlt_halted", 32'(halted),        32'd1);
      chk("hlt_req",    32'(bus.imem_req),  32'd0);
      tick();
      chk("hlt_req2",   32'(bus.imem_req),  32'd0);
      chk("hlt_valid2", 32'(valid_fd),      32'd1);
      flush = 1'b1; branch_target = 16'h0000;
      tick();
      flush = 1'b0;
      chk("unhlt_halted", 32'(halted),        32'd0);
      chk("unhlt_req",    32'(bus.imem_req),  32'd1);
      chk("unhlt_addr",   32'(bus.imem_addr), 32'h0000);
      tick();
      chk("unhlt_pc",    32'(curr_pc_fd),    32'h0000);
      chk("unhlt_instr", 32'(curr_instr_fd), 32'h1000);

      // PC wrap at 0xFFFE, then reset in the middle of a request.
      flush = 1'b1; branch_target = 16'hFFFE;
      tick();
      flush = 1'b0;
      chk("wrap_addr", 32'(bus.imem_addr), 32'hFFFE);
      tick();
      chk("wrap_pc",    32'(curr_pc_fd),    32'hFFFE);
      chk("wrap_npc",   32'(next_pc_fd),    32'h0000);
      chk("wrap_instr", 32'(curr_instr_fd), 32'hEFFE);
      chk("wrap_addr2", 32'(bus.imem_addr), 32'h0000);
      lat_cyc = 3;
      tick();
      chk("mid_req", 32'(bus.imem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_req",    32'(bus.imem_req),  32'd0);
      chk("arst_valid",  32'(valid_fd),      32'd0);
      chk("arst_instr",  32'(curr_instr_fd), 32'h0000);
      chk("arst_pc",     32'(curr_pc_fd),    32'h0000);
      chk("arst_npc",    32'(next_pc_fd),    32'h0000);
      chk("arst_halted", 32'(halted),        32'd0);
      tick();
      rst_n = 1'b1; lat_cyc = 1;
      tick();
      chk("rf_req",  32'(bus.imem_req),  32'd1);
      chk("rf_addr", 32'(bus.imem_addr), 32'h0000);
      tick();
      chk("rf_pc",    32'(curr_pc_fd),    32'h0000);
      chk("rf_valid", 32'(valid_fd),      32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
